// File: rtl/coolgirl_mapper.sv
// CoolGirl multicart mapper core. A lockable supervisor register set at
// $5000-$5FFF places each game in an outer flash window and selects the game
// mode (NROM, UxROM, AxROM, CNROM, MMC1). All state updates on the falling
// edge of m2; every output is combinational from state and live bus inputs.
module coolgirl_mapper #(
  parameter int unsigned CPU_ADDR_W = 27,
  parameter int unsigned CHR_ADDR_W = 18
) (
  input  logic                  m2,
  input  logic                  reset,
  input  logic                  romsel,
  input  logic                  cpu_rw_in,
  input  logic [14:0]           cpu_addr_in,
  input  logic [7:0]            cpu_data_in,
  output logic [CPU_ADDR_W-14:0] cpu_addr_out,
  output logic                  flash_we,
  output logic                  flash_oe,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic                  sram_oe,
  input  logic                  ppu_rd_in,
  input  logic                  ppu_wr_in,
  input  logic [13:0]           ppu_addr_in,
  output logic [CHR_ADDR_W-11:0] ppu_addr_out,
  output logic                  ppu_rd_out,
  output logic                  ppu_wr_out,
  output logic                  ppu_ciram_a10,
  output logic                  ppu_ciram_ce,
  output wire                   irq
);

  localparam int unsigned PrgW = CPU_ADDR_W - 14;
  localparam int unsigned ChrW = CHR_ADDR_W - 10;

  localparam logic [2:0] ModeUxrom = 3'd1;
  localparam logic [2:0] ModeAxrom = 3'd2;
  localparam logic [2:0] ModeCnrom = 3'd3;
  localparam logic [2:0] ModeMmc1  = 3'd4;

  // Supervisor registers
  logic [7:0] prg_base_q, prg_base_d;
  logic [7:0] prg_mask_q, prg_mask_d;
  logic [2:0] mode_q, mode_d;
  logic [1:0] mirror_q, mirror_d;
  logic       chr_we_en_q, chr_we_en_d;
  logic       prg_we_en_q, prg_we_en_d;
  logic       sram_en_q, sram_en_d;
  logic       lockout_q, lockout_d;

  // Game registers
  logic [7:0] bank_q, bank_d;
  logic [4:0] shift_q, shift_d;
  logic [4:0] control_q, control_d;
  logic [4:0] chr0_q, chr0_d;
  logic [4:0] chr1_q, chr1_d;
  logic [4:0] prg_q, prg_d;
  logic       prev_wr_q, prev_wr_d;

  logic       sup_wr;
  logic       game_wr;
  logic [4:0] mmc1_value;

  assign sup_wr  = romsel & (cpu_addr_in[14:12] == 3'b101) & ~cpu_rw_in & ~lockout_q;
  assign game_wr = ~romsel & ~cpu_rw_in;
  assign mmc1_value = {cpu_data_in[0], shift_q[4:1]};

  // Next-state for supervisor and game registers, including the MMC1 loader
  always_comb begin
    prg_base_d  = prg_base_q;
    prg_mask_d  = prg_mask_q;
    mode_d      = mode_q;
    mirror_d    = mirror_q;
    chr_we_en_d = chr_we_en_q;
    prg_we_en_d = prg_we_en_q;
    sram_en_d   = sram_en_q;
    lockout_d   = lockout_q;
    bank_d      = bank_q;
    shift_d     = shift_q;
    control_d   = control_q;
    chr0_d      = chr0_q;
    chr1_d      = chr1_q;
    prg_d       = prg_q;
    prev_wr_d   = game_wr;

    if (sup_wr) begin
      unique case (cpu_addr_in[1:0])
        2'd0: prg_base_d = cpu_data_in;
        2'd1: prg_mask_d = cpu_data_in;
        2'd2: begin
          mode_d      = cpu_data_in[2:0];
          mirror_d    = cpu_data_in[4:3];
          chr_we_en_d = cpu_data_in[5];
          prg_we_en_d = cpu_data_in[6];
          sram_en_d   = cpu_data_in[7];
        end
        2'd3: if (cpu_data_in[7]) lockout_d = 1'b1;
      endcase
    end

    if (game_wr) begin
      if (mode_q inside {ModeUxrom, ModeAxrom, ModeCnrom}) begin
        bank_d = cpu_data_in;
      end else if (mode_q == ModeMmc1 && !prev_wr_q) begin
        // Consecutive-cycle writes (RMW dummy writes) are dropped above
        if (cpu_data_in[7]) begin
          shift_d        = 5'b10000;
          control_d[3:2] = 2'b11;
        end else if (!shift_q[0]) begin
          shift_d = mmc1_value;
        end else begin
          // Marker bit reached position 0: this is the fifth write
          unique case (cpu_addr_in[14:13])
            2'd0: control_d = mmc1_value;
            2'd1: chr0_d    = mmc1_value;
            2'd2: chr1_d    = mmc1_value;
            2'd3: prg_d     = mmc1_value;
          endcase
          shift_d = 5'b10000;
        end
      end
    end
  end

  // State registers, falling edge of m2
  always_ff @(negedge m2 or negedge reset) begin
    if (!reset) begin
      prg_base_q  <= 8'h00;
      prg_mask_q  <= 8'h01;
      mode_q      <= 3'd0;
      mirror_q    <= 2'd0;
      chr_we_en_q <= 1'b1;
      prg_we_en_q <= 1'b0;
      sram_en_q   <= 1'b0;
      lockout_q   <= 1'b0;
      bank_q      <= 8'h00;
      shift_q     <= 5'b10000;
      control_q   <= 5'h0C;
      chr0_q      <= 5'h00;
      chr1_q      <= 5'h00;
      prg_q       <= 5'h00;
      prev_wr_q   <= 1'b0;
    end else begin
      prg_base_q  <= prg_base_d;
      prg_mask_q  <= prg_mask_d;
      mode_q      <= mode_d;
      mirror_q    <= mirror_d;
      chr_we_en_q <= chr_we_en_d;
      prg_we_en_q <= prg_we_en_d;
      sram_en_q   <= sram_en_d;
      lockout_q   <= lockout_d;
      bank_q      <= bank_d;
      shift_q     <= shift_d;
      control_q   <= control_d;
      chr0_q      <= chr0_d;
      chr1_q      <= chr1_d;
      prg_q       <= prg_d;
      prev_wr_q   <= prev_wr_d;
    end
  end

  // Inner 16 KB PRG bank selection per mode
  logic [7:0] inner16;
  logic       cpu_a14;
  assign cpu_a14 = cpu_addr_in[14];

  always_comb begin
    inner16 = {7'b0, cpu_a14};
    unique case (mode_q)
      ModeUxrom: inner16 = cpu_a14 ? 8'hFF : bank_q;
      ModeAxrom: inner16 = {4'b0, bank_q[2:0], cpu_a14};
      ModeMmc1: begin
        if (!control_q[3]) begin
          inner16 = {4'b0, prg_q[3:1], cpu_a14};
        end else if (!control_q[2]) begin
          inner16 = cpu_a14 ? {4'b0, prg_q[3:0]} : 8'h00;
        end else begin
          inner16 = cpu_a14 ? 8'h0F : {4'b0, prg_q[3:0]};
        end
      end
      default: inner16 = {7'b0, cpu_a14};
    endcase
  end

  // Outer window: base bits outside the mask, inner bank bits inside it
  logic [7:0]  prg_bank;
  logic [31:0] prg_bank_wide;
  assign prg_bank      = (prg_base_q & ~prg_mask_q) | (inner16 & prg_mask_q);
  assign prg_bank_wide = {24'b0, prg_bank};
  assign cpu_addr_out  = {prg_bank_wide[PrgW-1:0], cpu_addr_in[13]};

  // CHR bank selection in 1 KB units
  logic [31:0] chr_inner;
  always_comb begin
    chr_inner = {29'b0, ppu_addr_in[12:10]};
    unique case (mode_q)
      ModeCnrom: chr_inner = {21'b0, bank_q, ppu_addr_in[12:10]};
      ModeMmc1: begin
        if (!control_q[4]) begin
          chr_inner = {25'b0, chr0_q[4:1], ppu_addr_in[12:10]};
        end else begin
          chr_inner = {25'b0, (ppu_addr_in[12] ? chr1_q : chr0_q), ppu_addr_in[11:10]};
        end
      end
      default: chr_inner = {29'b0, ppu_addr_in[12:10]};
    endcase
  end
  assign ppu_addr_out = chr_inner[ChrW-1:0];

  // Nametable mirroring
  always_comb begin
    ppu_ciram_a10 = ppu_addr_in[10];
    if (mode_q == ModeAxrom) begin
      ppu_ciram_a10 = bank_q[4];
    end else if (mode_q == ModeMmc1) begin
      unique case (control_q[1:0])
        2'd0: ppu_ciram_a10 = 1'b0;
        2'd1: ppu_ciram_a10 = 1'b1;
        2'd2: ppu_ciram_a10 = ppu_addr_in[10];
        2'd3: ppu_ciram_a10 = ppu_addr_in[11];
      endcase
    end else begin
      unique case (mirror_q)
        2'd0: ppu_ciram_a10 = ppu_addr_in[10];
        2'd1: ppu_ciram_a10 = ppu_addr_in[11];
        2'd2: ppu_ciram_a10 = 1'b0;
        2'd3: ppu_ciram_a10 = 1'b1;
      endcase
    end
  end

  // Memory strobes, all active-low
  assign flash_oe = ~cpu_rw_in | romsel;
  assign flash_we = cpu_rw_in | romsel | ~prg_we_en_q;
  assign sram_ce  = ~(sram_en_q & m2 & romsel & cpu_addr_in[14] & cpu_addr_in[13]);
  assign sram_we  = cpu_rw_in;
  assign sram_oe  = ~cpu_rw_in;

  assign ppu_rd_out   = ppu_rd_in | ppu_addr_in[13];
  assign ppu_wr_out   = ppu_wr_in | ppu_addr_in[13] | ~chr_we_en_q;
  assign ppu_ciram_ce = ~ppu_addr_in[13];

  assign irq = 1'bz;

  // Bits that are decoded elsewhere on the board or reserved for later mappers
  logic unused_bits;
  assign unused_bits = ^{cpu_addr_in[11:2], ppu_addr_in[9:0], prg_q[4],
                         prg_bank_wide[31:PrgW], chr_inner[31:ChrW]};

endmodule

// File: tb/tb_coolgirl_mapper.sv
// Self-checking bench for coolgirl_mapper: expected values are pushed into a
// scoreboard queue as stimulus is applied and popped when outputs are sampled.
module tb_coolgirl_mapper;

  logic        m2 = 1'b0;
  logic        reset = 1'b0;
  logic        romsel = 1'b1;
  logic        cpu_rw_in = 1'b1;
  logic [14:0] cpu_addr_in = '0;
  logic [7:0]  cpu_data_in = '0;
  logic [13:0] cpu_addr_out;
  logic        flash_we, flash_oe, sram_ce, sram_we, sram_oe;
  logic        ppu_rd_in = 1'b1;
  logic        ppu_wr_in = 1'b1;
  logic [13:0] ppu_addr_in = '0;
  logic [7:0]  ppu_addr_out;
  logic        ppu_rd_out, ppu_wr_out, ppu_ciram_a10, ppu_ciram_ce;
  wire         irq;

  coolgirl_mapper #(
    .CPU_ADDR_W(27),
    .CHR_ADDR_W(18)
  ) dut (
    .m2           (m2),
    .reset        (reset),
    .romsel       (romsel),
    .cpu_rw_in    (cpu_rw_in),
    .cpu_addr_in  (cpu_addr_in),
    .cpu_data_in  (cpu_data_in),
    .cpu_addr_out (cpu_addr_out),
    .flash_we     (flash_we),
    .flash_oe     (flash_oe),
    .sram_ce      (sram_ce),
    .sram_we      (sram_we),
    .sram_oe      (sram_oe),
    .ppu_rd_in    (ppu_rd_in),
    .ppu_wr_in    (ppu_wr_in),
    .ppu_addr_in  (ppu_addr_in),
    .ppu_addr_out (ppu_addr_out),
    .ppu_rd_out   (ppu_rd_out),
    .ppu_wr_out   (ppu_wr_out),
    .ppu_ciram_a10(ppu_ciram_a10),
    .ppu_ciram_ce (ppu_ciram_ce),
    .irq          (irq)
  );

  always #5 m2 = ~m2;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_val(e.tag, obs, e.val);
    end
  endtask

  // One CPU write cycle: drive during m2 high, state latches on the falling edge
  task automatic bus_wr(input logic rs, input logic [14:0] addr, input logic [7:0] data);
    @(posedge m2);
    #1;
    romsel      = rs;
    cpu_rw_in   = 1'b0;
    cpu_addr_in = addr;
    cpu_data_in = data;
    @(negedge m2);
    #1;
    cpu_rw_in   = 1'b1;
    romsel      = 1'b1;
    cpu_addr_in = '0;
  endtask

  task automatic idle();
    @(posedge m2);
    @(negedge m2);
    #1;
  endtask

  // Five serial MMC1 writes, LSB first, separated by idle cycles
  task automatic mmc1_load(input logic [14:0] addr, input logic [4:0] value);
    for (int i = 0; i < 5; i++) begin
      bus_wr(1'b0, addr, {7'b0, value[i]});
      idle();
    end
  endtask

  task automatic rd_chk(input string tag, input logic [14:0] addr, input logic [13:0] exp);
    romsel      = 1'b0;
    cpu_rw_in   = 1'b1;
    cpu_addr_in = addr;
    push_exp(tag, {18'b0, exp});
    #1;
    pop_check({18'b0, cpu_addr_out});
    romsel = 1'b1;
  endtask

  // sel: 0 = ciram_a10, 1 = chr address, 2 = ppu_wr_out during a PPU write
  task automatic ppu_chk(input string tag, input logic [13:0] addr, input int sel,
                         input logic [7:0] exp);
    ppu_addr_in = addr;
    if (sel == 2) ppu_wr_in = 1'b0;
    push_exp(tag, {24'b0, exp});
    #1;
    case (sel)
      0:       pop_check({31'b0, ppu_ciram_a10});
      1:       pop_check({24'b0, ppu_addr_out});
      default: pop_check({31'b0, ppu_wr_out});
    endcase
    ppu_wr_in = 1'b1;
  endtask

  task automatic pulse_reset();
    #2;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    #12 reset = 1'b1;

    // Reset state: menu in first 32 KB
    rd_chk("rst_8000", 15'h0000, 14'h0000);
    rd_chk("rst_c000", 15'h4000, 14'h0002);
    romsel = 1'b0; cpu_rw_in = 1'b1; cpu_addr_in = '0;
    push_exp("rst_flash_we", 1);
    #1 pop_check({31'b0, flash_we});
    push_exp("rst_flash_oe", 0);
    pop_check({31'b0, flash_oe});
    push_exp("rst_sram_ce", 1);
    pop_check({31'b0, sram_ce});
    romsel = 1'b1;
    ppu_chk("rst_ciram_v", 14'h2400, 0, 8'h01);
    ppu_chk("rst_chr", 14'h1C00, 1, 8'h07);

    // Lockout blocks further supervisor writes
    bus_wr(1'b1, 15'h5002, 8'h00);
    bus_wr(1'b1, 15'h5003, 8'h80);
    bus_wr(1'b1, 15'h5000, 8'h12);
    rd_chk("lock_c000", 15'h4000, 14'h0002);
    ppu_chk("chr_we_off", 14'h0000, 2, 8'h01);

    // Reset clears lockout
    pulse_reset();

    // UxROM in an outer window
    bus_wr(1'b1, 15'h5000, 8'h40);
    bus_wr(1'b1, 15'h5001, 8'h07);
    bus_wr(1'b1, 15'h5002, 8'h21);
    bus_wr(1'b0, 15'h0000, 8'h0B);
    rd_chk("ux_8000", 15'h0000, 14'h0086);
    rd_chk("ux_a000", 15'h2000, 14'h0087);
    rd_chk("ux_c000", 15'h4000, 14'h008E);
    ppu_chk("ux_ciram_2400", 14'h2400, 0, 8'h01);
    ppu_chk("ux_ciram_2800", 14'h2800, 0, 8'h00);
    ppu_chk("ux_chr", 14'h1C00, 1, 8'h07);
    ppu_chk("chr_we_on", 14'h0000, 2, 8'h00);

    // AxROM: single-screen from bank bit 4
    bus_wr(1'b1, 15'h5002, 8'h02);
    bus_wr(1'b0, 15'h0000, 8'h13);
    rd_chk("ax_8000", 15'h0000, 14'h008C);
    rd_chk("ax_c000", 15'h4000, 14'h008E);
    ppu_chk("ax_ciram_2000", 14'h2000, 0, 8'h01);
    ppu_chk("ax_ciram_2800", 14'h2800, 0, 8'h01);
    ppu_chk("ax_ciram_2c00", 14'h2C00, 0, 8'h01);

    // MMC1: partial shift is discarded by reset
    bus_wr(1'b1, 15'h5000, 8'h00);
    bus_wr(1'b1, 15'h5001, 8'h0F);
    bus_wr(1'b1, 15'h5002, 8'h04);
    bus_wr(1'b0, 15'h6000, 8'h01);
    idle();
    bus_wr(1'b0, 15'h6000, 8'h01);
    pulse_reset();
    rd_chk("mid_rst_c000", 15'h4000, 14'h0002);
    bus_wr(1'b1, 15'h5000, 8'h00);
    bus_wr(1'b1, 15'h5001, 8'h0F);
    bus_wr(1'b1, 15'h5002, 8'h04);
    mmc1_load(15'h6000, 5'h0D);
    rd_chk("m1_8000", 15'h0000, 14'h001A);
    rd_chk("m1_c000", 15'h4000, 14'h001E);
    ppu_chk("m1_ciram0", 14'h2400, 0, 8'h00);

    // MMC1 control = 0x12: 32 KB PRG, 4 KB CHR, vertical
    mmc1_load(15'h0000, 5'h12);
    rd_chk("m1_32k_8000", 15'h0000, 14'h0018);
    rd_chk("m1_32k_c000", 15'h4000, 14'h001A);
    ppu_chk("m1_ciram_2400", 14'h2400, 0, 8'h01);
    ppu_chk("m1_ciram_2800", 14'h2800, 0, 8'h00);
    mmc1_load(15'h4000, 5'h05);
    mmc1_load(15'h2000, 5'h0A);
    ppu_chk("m1_chr1", 14'h1C00, 1, 8'h17);
    ppu_chk("m1_chr0", 14'h0C00, 1, 8'h2B);

    // Back-to-back write: the second is dropped, prg becomes 2
    bus_wr(1'b0, 15'h6000, 8'h00);
    idle();
    bus_wr(1'b0, 15'h6000, 8'h01);
    bus_wr(1'b0, 15'h6000, 8'h01);
    idle();
    for (int i = 0; i < 3; i++) begin
      bus_wr(1'b0, 15'h6000, 8'h00);
      idle();
    end
    rd_chk("b2b_8000", 15'h0000, 14'h0004);
    rd_chk("b2b_c000", 15'h4000, 14'h0006);

    // Reset write mid-sequence restarts the shifter and forces fix-$C000
    bus_wr(1'b0, 15'h6000, 8'h01);
    idle();
    bus_wr(1'b0, 15'h6000, 8'h01);
    idle();
    bus_wr(1'b0, 15'h6000, 8'h80);
    idle();
    mmc1_load(15'h6000, 5'h05);
    rd_chk("d7_8000", 15'h0000, 14'h000A);
    rd_chk("d7_c000", 15'h4000, 14'h001E);
    ppu_chk("d7_ciram", 14'h2400, 0, 8'h01);
    ppu_chk("d7_chr", 14'h1C00, 1, 8'h17);

    // SRAM and flash programming strobes
    bus_wr(1'b1, 15'h5002, 8'hC0);
    @(posedge m2);
    #1;
    romsel = 1'b1; cpu_rw_in = 1'b0; cpu_addr_in = 15'h6000; cpu_data_in = 8'h5A;
    push_exp("sram_ce_hi", 0);
    #1 pop_check({31'b0, sram_ce});
    push_exp("sram_we", 0);
    pop_check({31'b0, sram_we});
    @(negedge m2);
    #1;
    push_exp("sram_ce_lo", 1);
    pop_check({31'b0, sram_ce});
    cpu_rw_in = 1'b1; cpu_addr_in = '0;
    @(posedge m2);
    #1;
    romsel = 1'b0; cpu_rw_in = 1'b0; cpu_addr_in = 15'h0000; cpu_data_in = 8'h00;
    push_exp("flash_we_prog", 0);
    #1 pop_check({31'b0, flash_we});
    push_exp("flash_oe_prog", 1);
    pop_check({31'b0, flash_oe});
    @(negedge m2);
    #1;
    romsel = 1'b1; cpu_rw_in = 1'b1;
    ppu_chk("chr_we_off2", 14'h0000, 2, 8'h01);

    if (exp_q.size() != 0) check_val("sb_leftover", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
